// File: rtl/stk_pkg.sv
// Shared types and constants for the descriptor stack block.
package stk_pkg;

  localparam int PTR_W = 8;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam int STK_SCHED_REQ_N = 4;
  localparam int STK_SCHED_QUOTA = 16;

  typedef enum logic [1:0] {
    SCHED_INIT = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_HALT = 2'd2
  } stk_sched_state_t;

endpackage

// File: rtl/stk_alloc_sched_cnt.sv
// Per-requester outstanding-descriptor counter, saturating at 0 and QUOTA.
module stk_alloc_sched_cnt #(
  parameter int QUOTA = 16,
  parameter int CNT_W = $clog2(QUOTA+1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_quota_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; each direction saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_W'(QUOTA))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign at_quota_o  = (cnt_q == CNT_W'(QUOTA));
  // A return against an empty count is a protocol error, even if a grant
  // to the same requester lands in the same cycle.
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/stk_rr_arb.sv
// Round-robin arbiter: priority starts at ptr_q and moves past the winner
// only when the caller reports that the pick was actually used (adv_i).
module stk_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N-1:0]     req_i,
  input  logic             adv_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win;
  logic [N-1:0]     pick;
  logic             found;

  // Scan requesters starting at the priority pointer, first hit wins.
  always_comb begin
    pick  = '0;
    win   = '0;
    found = 1'b0;
    cand  = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[cand]) begin
        found      = 1'b1;
        win        = cand;
        pick[cand] = 1'b1;
      end
      cand = (cand == IDX_W'(N-1)) ? '0 : cand + 1'b1;
    end
  end

  assign gnt_o = pick;
  assign idx_o = win;
  assign any_o = found;

  // Next priority position: one past the winner, only on a used grant.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (win == IDX_W'(N-1)) ? '0 : win + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stk_alloc_sched.sv
// Round-robin, quota-limited scheduler in front of the descriptor allocator.
// Handshake: a requester holds i_req_vld[i] high; the request is consumed in
// the cycle o_req_gnt[i] is 1. There is no response backpressure: the owner
// named by o_rsp_id must take o_rsp_ptr in the cycle o_rsp_vld is 1, which
// is exactly two cycles after its grant.
module stk_alloc_sched
  import stk_pkg::*;
#(
  parameter int REQ_N    = STK_SCHED_REQ_N,
  parameter int QUOTA    = STK_SCHED_QUOTA,
  parameter int REQ_ID_W = $clog2(REQ_N),
  parameter int CNT_W    = $clog2(QUOTA+1)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [REQ_N-1:0]       i_req_vld,
  output logic [REQ_N-1:0]       o_req_gnt,
  output logic                   o_rsp_vld,
  output logic [REQ_ID_W-1:0]    o_rsp_id,
  output logic [PTR_W-1:0]       o_rsp_ptr,
  input  logic                   i_free_vld,
  input  logic [REQ_ID_W-1:0]    i_free_id,
  input  logic [PTR_W-1:0]       i_free_ptr,
  input  logic                   i_halt,
  output logic                   o_ad_alloc,
  input  logic                   i_ad_empty_r,
  input  logic                   i_ad_busy_r,
  input  logic [PTR_W-1:0]       i_lk_ptr_w,
  output logic                   o_dealloc_vld,
  output logic [PTR_W-1:0]       o_dealloc_ptr,
  output logic [1:0]             o_state_r,
  output logic [REQ_N*CNT_W-1:0] o_cnt_r,
  output logic                   o_err_r
);

  localparam logic [REQ_ID_W:0] REQ_N_W = (REQ_ID_W+1)'(REQ_N);

  stk_sched_state_t state_q, state_d;
  logic             init_seen_q;

  logic [REQ_N-1:0]    at_quota;
  logic [REQ_N-1:0]    underflow;
  logic [REQ_N-1:0]    elig;
  logic [REQ_N-1:0]    pick;
  logic [REQ_N-1:0]    gnt_vec;
  logic [REQ_ID_W-1:0] pick_idx;
  logic                pick_any;
  logic                gnt_en;
  logic [CNT_W-1:0]    cnt_w [REQ_N];

  logic                lk_vld_q;
  logic [REQ_ID_W-1:0] lk_id_q;
  logic                rsp_vld_q;
  logic [REQ_ID_W-1:0] rsp_id_q;
  ptr_t                rsp_ptr_q;
  logic                err_q, err_d;
  logic                free_id_bad;

  // Start-up, run and halt sequencing; an unused encoding falls back to INIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_INIT: if (init_seen_q && !i_ad_busy_r) state_d = SCHED_RUN;
      SCHED_RUN:  if (i_halt)                      state_d = SCHED_HALT;
      SCHED_HALT: if (!i_halt)                     state_d = SCHED_RUN;
      default:                                     state_d = SCHED_INIT;
    endcase
  end

  // State register; init_seen_q keeps INIT for a full cycle after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= SCHED_INIT;
      init_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_seen_q <= 1'b1;
    end
  end

  // Eligibility uses the registered count, so a same-cycle free does not
  // reopen a requester sitting at its quota.
  assign elig = i_req_vld & ~at_quota;

  stk_rr_arb #(
    .N     (REQ_N),
    .IDX_W (REQ_ID_W)
  ) u_arb (
    .clk    (clk),
    .arst_n (arst_n),
    .req_i  (elig),
    .adv_i  (gnt_en),
    .gnt_o  (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A free in the same cycle refills an empty allocator via its bypass.
  assign gnt_en     = (state_q == SCHED_RUN) && pick_any && (!i_ad_empty_r || i_free_vld);
  assign gnt_vec    = gnt_en ? pick : '0;
  assign o_req_gnt  = gnt_vec;
  assign o_ad_alloc = gnt_en;

  for (genvar i = 0; i < REQ_N; i++) begin : g_cnt
    stk_alloc_sched_cnt #(
      .QUOTA (QUOTA),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk         (clk),
      .arst_n      (arst_n),
      .inc_i       (gnt_vec[i]),
      .dec_i       (i_free_vld && (i_free_id == REQ_ID_W'(i))),
      .cnt_o       (cnt_w[i]),
      .at_quota_o  (at_quota[i]),
      .underflow_o (underflow[i])
    );
    assign o_cnt_r[i*CNT_W +: CNT_W] = cnt_w[i];
  end

  // Returns go straight through to the allocator, even when erroneous.
  assign o_dealloc_vld = i_free_vld;
  assign o_dealloc_ptr = i_free_ptr;

  assign free_id_bad = ({1'b0, i_free_id} >= REQ_N_W);

  // Sticky protocol error: return against an empty count or an unknown id.
  always_comb begin
    err_d = err_q;
    if (i_free_vld && (free_id_bad || (|underflow))) err_d = 1'b1;
  end

  // Response pipeline: grant at T, lookup pointer captured at T+1,
  // response presented at T+2.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lk_vld_q  <= 1'b0;
      lk_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_ptr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      lk_vld_q  <= gnt_en;
      if (gnt_en) lk_id_q <= pick_idx;
      rsp_vld_q <= lk_vld_q;
      if (lk_vld_q) begin
        rsp_id_q  <= lk_id_q;
        rsp_ptr_q <= i_lk_ptr_w;
      end
      err_q     <= err_d;
    end
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_id  = rsp_id_q;
  assign o_rsp_ptr = rsp_ptr_q;
  assign o_state_r = state_q;
  assign o_err_r   = err_q;

endmodule
